// File: rtl/rmii_tx.sv
// RMII transmit MAC serializer: frames a valid/ready byte stream as preamble, SFD,
// payload, optional zero pad and CRC-32 FCS at one dibit per refclk, then holds the IFG.
module rmii_tx #(
    parameter int IFG_BYTES = 12,
    parameter int PAD_EN    = 1
) (
    input  logic       refclk,
    input  logic       rst_l,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [1:0] txd,
    output logic       tx_en,
    output logic       busy,
    output logic       underrun
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } state_t;

    localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);
    localparam logic [7:0]  PRE_LAST = 8'd6;
    localparam logic [7:0]  FCS_LAST = 8'd3;
    localparam logic [5:0]  MIN_LEN  = 6'd60;
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_dibit_cnt;
    logic [7:0]  r_cnt;
    logic [5:0]  r_len;
    logic [5:0]  w_len_next;
    logic [7:0]  r_byte;
    logic        r_last;
    logic [31:0] r_crc;
    logic [31:0] w_fcs;
    logic [1:0]  r_txd;
    logic [1:0]  w_dibit;
    logic        r_tx_en;
    logic        w_tx_en;
    logic        r_busy;
    logic        r_underrun;
    logic        w_abort;
    logic        w_accept;
    logic        w_byte_end;
    logic        w_need_pad;

    // Reflected CRC-32 advanced by one dibit, bit 0 first, so it matches the wire order.
    function automatic logic [31:0] crc_dibit(input logic [31:0] crc, input logic [1:0] d);
        logic [31:0] c;
        c = crc;
        for (int unsigned i = 0; i < 2; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY;
            else             c = c >> 1;
        end
        return c;
    endfunction

    assign w_byte_end = (r_dibit_cnt == 2'd3);
    assign w_len_next = (r_len == MIN_LEN) ? MIN_LEN : r_len + 6'd1;
    assign w_need_pad = (PAD_EN != 0) && (w_len_next < MIN_LEN);
    assign w_fcs      = ~r_crc;

    assign s_ready  = w_byte_end &&
                      ((r_state == ST_SFD) || ((r_state == ST_DATA) && !r_last));
    assign w_accept = s_ready && s_valid;

    always_ff @(posedge refclk or negedge rst_l) begin
        if (!rst_l) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_dibit = 2'b00;
        w_tx_en = 1'b0;
        w_abort = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (s_valid) w_next = ST_PRE;
            end
            ST_PRE: begin
                w_tx_en = 1'b1;
                w_dibit = 2'b01;
                if (w_byte_end && (r_cnt == PRE_LAST)) w_next = ST_SFD;
            end
            ST_SFD: begin
                w_tx_en = 1'b1;
                w_dibit = w_byte_end ? 2'b11 : 2'b01;
                // A frame with no first byte at SFD end is starved like a DATA underrun.
                if (w_byte_end) begin
                    if (s_valid) begin
                        w_next = ST_DATA;
                    end else begin
                        w_abort = 1'b1;
                        w_next  = ST_IFG;
                    end
                end
            end
            ST_DATA: begin
                w_tx_en = 1'b1;
                w_dibit = r_byte[{r_dibit_cnt, 1'b0} +: 2];
                if (w_byte_end) begin
                    if (r_last) begin
                        w_next = w_need_pad ? ST_PAD : ST_FCS;
                    end else if (!s_valid) begin
                        w_abort = 1'b1;
                        w_next  = ST_IFG;
                    end
                end
            end
            ST_PAD: begin
                w_tx_en = 1'b1;
                if (w_byte_end && (w_len_next == MIN_LEN)) w_next = ST_FCS;
            end
            ST_FCS: begin
                w_tx_en = 1'b1;
                w_dibit = w_fcs[{r_cnt[1:0], r_dibit_cnt, 1'b0} +: 2];
                if (w_byte_end && (r_cnt == FCS_LAST)) w_next = ST_IFG;
            end
            ST_IFG: begin
                if (w_byte_end && (r_cnt == IFG_LAST)) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge refclk or negedge rst_l) begin
        if (!rst_l) begin
            r_dibit_cnt <= '0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_byte      <= '0;
            r_last      <= 1'b0;
            r_crc       <= '0;
            r_txd       <= '0;
            r_tx_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_txd      <= w_dibit;
            r_tx_en    <= w_tx_en;
            r_busy     <= (w_next != ST_IDLE);
            r_underrun <= w_abort;

            r_dibit_cnt <= (r_state == ST_IDLE) ? 2'd0 : r_dibit_cnt + 2'd1;

            if (w_next != r_state) r_cnt <= '0;
            else if (w_byte_end)   r_cnt <= r_cnt + 8'd1;

            if (r_state == ST_SFD) begin
                r_len <= '0;
                r_crc <= '1;
            end else if ((r_state == ST_DATA) || (r_state == ST_PAD)) begin
                r_crc <= crc_dibit(r_crc, w_dibit);
                if (w_byte_end) r_len <= w_len_next;
            end

            if (w_accept) begin
                r_byte <= s_data;
                r_last <= s_last;
            end
        end
    end

    assign txd      = r_txd;
    assign tx_en    = r_tx_en;
    assign busy     = r_busy;
    assign underrun = r_underrun;

endmodule

// File: tb/tb_rmii_tx.sv
// Directed/randomized bench for rmii_tx: one padded and one unpadded instance, each
// frame rebuilt from payload bytes with a bytewise CRC-32 reference and compared.
module tb_rmii_tx;
    localparam int IFG = 12;

    logic       refclk = 1'b0;
    logic       rst_l;
    logic [7:0] s_data   [2];
    logic       s_valid  [2];
    logic       s_last   [2];
    logic       s_ready  [2];
    logic [1:0] txd      [2];
    logic       tx_en    [2];
    logic       busy     [2];
    logic       underrun [2];

    int checks = 0;
    int errors = 0;

    always #10 refclk = ~refclk;

    // Index 0: PAD_EN=1, index 1: PAD_EN=0.
    rmii_tx #(.IFG_BYTES(IFG), .PAD_EN(1)) dut_pad (
        .refclk(refclk), .rst_l(rst_l),
        .s_data(s_data[0]), .s_valid(s_valid[0]), .s_last(s_last[0]), .s_ready(s_ready[0]),
        .txd(txd[0]), .tx_en(tx_en[0]), .busy(busy[0]), .underrun(underrun[0])
    );

    rmii_tx #(.IFG_BYTES(IFG), .PAD_EN(0)) dut_nopad (
        .refclk(refclk), .rst_l(rst_l),
        .s_data(s_data[1]), .s_valid(s_valid[1]), .s_last(s_last[1]), .s_ready(s_ready[1]),
        .txd(txd[1]), .tx_en(tx_en[1]), .busy(busy[1]), .underrun(underrun[1])
    );

    // ---------------- line monitor ----------------
    int         cyc = 0;
    logic       en_q   [2];
    logic       busy_q [2];
    logic [7:0] sh     [2];
    int         cur_dib [2];
    int         cur_cyc [2];
    int         wr      [2];
    int         nfr     [2];
    int         last_fall [2];
    int         ur_cnt  [2];
    int         ur_t    [2];
    int         busy_rise_t [2];
    int         busy_fall_t [2];
    int         fr_start  [2][16];
    int         fr_nbytes [2][16];
    int         fr_cyc    [2][16];
    int         fr_gap    [2][16];
    int         fr_rise   [2][16];
    int         fr_fall   [2][16];
    logic [7:0] hist [2][8192];

    initial begin
        for (int g = 0; g < 2; g++) begin
            en_q[g] = 1'b0; busy_q[g] = 1'b0; sh[g] = '0;
            cur_dib[g] = 0; cur_cyc[g] = 0; wr[g] = 0; nfr[g] = 0;
            last_fall[g] = -1000; ur_cnt[g] = 0; ur_t[g] = 0;
            busy_rise_t[g] = 0; busy_fall_t[g] = 0;
        end
        forever begin
            @(negedge refclk);
            for (int g = 0; g < 2; g++) begin
                if (tx_en[g] && !en_q[g]) begin
                    fr_start[g][nfr[g] % 16] = wr[g];
                    fr_gap[g][nfr[g] % 16]   = cyc - last_fall[g];
                    fr_rise[g][nfr[g] % 16]  = cyc;
                    cur_dib[g] = 0;
                    cur_cyc[g] = 0;
                end
                if (tx_en[g]) begin
                    cur_cyc[g]++;
                    sh[g] = {txd[g], sh[g][7:2]};
                    if (cur_dib[g] % 4 == 3) begin
                        hist[g][wr[g] & 8191] = sh[g];
                        wr[g]++;
                    end
                    cur_dib[g]++;
                end
                if (!tx_en[g] && en_q[g]) begin
                    fr_cyc[g][nfr[g] % 16]    = cur_cyc[g];
                    fr_nbytes[g][nfr[g] % 16] = cur_dib[g] / 4;
                    fr_fall[g][nfr[g] % 16]   = cyc;
                    last_fall[g] = cyc;
                    nfr[g]++;
                end
                if (underrun[g]) begin
                    ur_cnt[g]++;
                    ur_t[g] = cyc;
                end
                if (busy[g] && !busy_q[g]) busy_rise_t[g] = cyc;
                if (!busy[g] && busy_q[g]) busy_fall_t[g] = cyc;
                en_q[g]   = tx_en[g];
                busy_q[g] = busy[g];
            end
            cyc++;
        end
    end

    initial begin
        #(4_000_000);
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [7:0] pay [4][128];
    logic [7:0] exp_b [256];
    int         exp_n;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'd0, b};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    // trunc > 0: frame aborted after that many payload bytes, no pad/FCS.
    task automatic build_exp(input int slot, input int n, input bit pad, input int trunc);
        logic [31:0] crc;
        logic [7:0]  b;
        int          len;
        exp_n = 0;
        for (int i = 0; i < 7; i++) begin exp_b[exp_n] = 8'h55; exp_n++; end
        exp_b[exp_n] = 8'hD5; exp_n++;
        if (trunc > 0) begin
            for (int i = 0; i < trunc; i++) begin exp_b[exp_n] = pay[slot][i]; exp_n++; end
            return;
        end
        len = (pad && n < 60) ? 60 : n;
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) begin
            b = (i < n) ? pay[slot][i] : 8'h00;
            exp_b[exp_n] = b; exp_n++;
            crc = crc_byte(crc, b);
        end
        crc = ~crc;
        for (int k = 0; k < 4; k++) begin exp_b[exp_n] = crc[8*k +: 8]; exp_n++; end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_frame(input int sel, input int f, input int slot, input int n,
                             input bit pad, input int trunc, input int exp_cyc, input string tag);
        int nbad;
        int st;
        nbad = 0;
        build_exp(slot, n, pad, trunc);
        st = fr_start[sel][f % 16];
        for (int i = 0; i < exp_n; i++)
            if (hist[sel][(st + i) & 8191] !== exp_b[i]) nbad++;
        check({tag, "_nbytes"}, fr_nbytes[sel][f % 16], exp_n);
        check({tag, "_bad_bytes"}, nbad, 0);
        check({tag, "_cycles"}, fr_cyc[sel][f % 16], exp_cyc);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive_frame(input int sel, input int slot, input int n, input int drop);
        int i;
        int budget;
        i = 0;
        budget = 0;
        s_data[sel]  = pay[slot][0];
        s_last[sel]  = (n == 1);
        s_valid[sel] = 1'b1;
        while (i < n && budget < 4000) begin
            @(negedge refclk);
            budget++;
            if (s_ready[sel]) begin
                @(posedge refclk);
                #1;
                i++;
                if (i == drop) break;
                if (i < n) begin
                    s_data[sel] = pay[slot][i];
                    s_last[sel] = (i == n - 1);
                end
            end
        end
        s_valid[sel] = 1'b0;
        s_last[sel]  = 1'b0;
        if (drop > 0) begin
            check("drop_point", i, drop);
            // keep valid low through the next ready slot so the frame starves
            budget = 0;
            while (budget < 16) begin
                @(negedge refclk);
                budget++;
                if (s_ready[sel]) begin
                    @(posedge refclk);
                    #1;
                    break;
                end
            end
        end else begin
            check("bytes_taken", i, n);
        end
    endtask

    task automatic wait_frames(input int sel, input int target);
        int t;
        t = 0;
        while (nfr[sel] < target && t < 5000) begin
            @(negedge refclk);
            #1;
            t++;
        end
        check("frame_done", 32'(nfr[sel] >= target), 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int         f;
        int         n;
        int         ur0;
        int         st;
        int         t;
        logic       any;
        logic [31:0] fcs;

        rst_l = 1'b0;
        for (int g = 0; g < 2; g++) begin
            s_valid[g] = 1'b0; s_last[g] = 1'b0; s_data[g] = '0;
        end
        repeat (3) @(posedge refclk);
        #3 rst_l = 1'b1;

        // Reset with no traffic stays quiet.
        any = 1'b0;
        repeat (20) begin
            @(negedge refclk);
            for (int g = 0; g < 2; g++)
                any = any | tx_en[g] | busy[g] | s_ready[g] | underrun[g] | (|txd[g]);
        end
        check("idle_quiet", any, 0);
        check("rst_tx_en", tx_en[0], 0);
        check("rst_txd", txd[0], 0);
        check("rst_s_ready", s_ready[1], 0);
        check("rst_busy", busy[1], 0);

        // Unpadded "123456789": 84 cycles, FCS CBF43926.
        for (int i = 0; i < 9; i++) pay[0][i] = 8'(8'h31 + i);
        f = nfr[1];
        drive_frame(1, 0, 9, 0);
        wait_frames(1, f + 1);
        cmp_frame(1, f, 0, 9, 1'b0, 0, 84, "nopad_check");
        st  = fr_start[1][f % 16];
        fcs = {hist[1][(st + 20) & 8191], hist[1][(st + 19) & 8191],
               hist[1][(st + 18) & 8191], hist[1][(st + 17) & 8191]};
        check("nopad_fcs", fcs, 32'hCBF43926);
        check("busy_lead", fr_rise[1][f % 16] - busy_rise_t[1], 1);
        repeat (60) @(negedge refclk);
        #1;
        check("busy_tail", busy_fall_t[1] - fr_fall[1][f % 16], IFG * 4 - 1);
        check("post_ifg_idle", tx_en[1] | busy[1], 0);

        // Padded single byte 0xAB: 60 bytes on the wire plus FCS.
        pay[1][0] = 8'hAB;
        f = nfr[0];
        drive_frame(0, 1, 1, 0);
        wait_frames(0, f + 1);
        cmp_frame(0, f, 1, 1, 1'b1, 0, 288, "pad1");
        repeat (60) @(negedge refclk);

        // Back-to-back 64-byte frames offered continuously.
        for (int i = 0; i < 64; i++) begin
            pay[0][i] = 8'($urandom);
            pay[1][i] = 8'($urandom);
        end
        f = nfr[0];
        drive_frame(0, 0, 64, 0);
        drive_frame(0, 1, 64, 0);
        wait_frames(0, f + 2);
        cmp_frame(0, f,     0, 64, 1'b1, 0, 304, "b2b_a");
        cmp_frame(0, f + 1, 1, 64, 1'b1, 0, 304, "b2b_b");
        check("b2b_gap", fr_gap[0][(f + 1) % 16], IFG * 4 + 1);
        repeat (60) @(negedge refclk);

        // Underrun after the 5th byte, then a normal frame right behind it.
        for (int i = 0; i < 20; i++) pay[2][i] = 8'($urandom);
        n = $urandom_range(1, 90);
        for (int i = 0; i < n; i++) pay[3][i] = 8'($urandom);
        ur0 = ur_cnt[0];
        f   = nfr[0];
        drive_frame(0, 2, 20, 5);
        drive_frame(0, 3, n, 0);
        wait_frames(0, f + 2);
        cmp_frame(0, f, 2, 20, 1'b1, 5, 52, "urun");
        check("urun_pulses", ur_cnt[0] - ur0, 1);
        check("urun_to_fall", fr_fall[0][f % 16] - ur_t[0], 1);
        cmp_frame(0, f + 1, 3, n, 1'b1, 0, 32 + 4 * ((n < 60) ? 60 : n) + 16, "after_urun");
        check("after_urun_gap", fr_gap[0][(f + 1) % 16], IFG * 4 + 1);
        repeat (60) @(negedge refclk);

        // Asynchronous reset in the middle of DATA.
        s_data[0]  = 8'($urandom);
        s_last[0]  = 1'b0;
        s_valid[0] = 1'b1;
        t = 0;
        while (!(tx_en[0] && cur_dib[0] >= 60) && t < 500) begin
            @(negedge refclk);
            #1;
            t++;
        end
        check("midframe_reached", 32'(cur_dib[0] >= 60), 1);
        #3 rst_l = 1'b0;
        #1;
        check("arst_tx_en", tx_en[0], 0);
        check("arst_txd", txd[0], 0);
        check("arst_busy", busy[0], 0);
        check("arst_s_ready", s_ready[0], 0);
        s_valid[0] = 1'b0;
        repeat (3) @(posedge refclk);
        #3 rst_l = 1'b1;
        repeat (8) @(negedge refclk);
        #1;
        check("post_rst_idle", tx_en[0] | busy[0], 0);
        n = $urandom_range(40, 80);
        for (int i = 0; i < n; i++) pay[2][i] = 8'($urandom);
        f = nfr[0];
        drive_frame(0, 2, n, 0);
        wait_frames(0, f + 1);
        cmp_frame(0, f, 2, n, 1'b1, 0, 32 + 4 * ((n < 60) ? 60 : n) + 16, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
